// File: rtl/reorder_buffer_pkg.sv
// Shared core constants for the reorder buffer and its clients (rs, FUs).
// Tag width and writeback port numbering are defined once here.
package reorder_buffer_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ROB_DEPTH  = 8;
   localparam int unsigned ROB_TAG_W  = $clog2(ROB_DEPTH);
   localparam int unsigned ROB_NWB    = 3;

   localparam int unsigned WB_ARITH = 0;
   localparam int unsigned WB_MUL   = 1;
   localparam int unsigned WB_LSU   = 2;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       pc;
   } rob_info_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Circular-buffer pointer with an extra wrap bit above the index, so that
// full and empty can be told apart when the indices match.
module rob_ptr #(
   parameter int unsigned TAG_W = 3
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           clear_i,
   input  logic           inc_i,
   output logic [TAG_W:0] ptr_o
);

   localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ptr_o <= '0;
      end else if (clear_i) begin
         ptr_o <= '0;
      end else if (inc_i) begin
         ptr_o <= ptr_o + PTR_ONE;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries allocated in program order, completed
// out of order by tag, retired one per cycle onto the regfile write port.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH,
   parameter int unsigned TAG_W = ROB_TAG_W,
   parameter int unsigned NWB   = ROB_NWB
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   input  logic                  alloc_valid_i,
   output logic                  alloc_ready_o,
   output logic [TAG_W-1:0]      alloc_tag_o,
   input  logic [XLEN-1:0]       alloc_pc_i,
   input  logic [REG_ADDR_W-1:0] alloc_rd_addr_i,
   input  logic                  alloc_rd_we_i,
   input  logic [NWB-1:0]        wb_valid_i,
   input  logic [NWB*TAG_W-1:0]  wb_tag_i,
   input  logic [NWB*XLEN-1:0]   wb_value_i,
   output logic                  commit_valid_o,
   output logic [TAG_W-1:0]      commit_tag_o,
   output logic [XLEN-1:0]       commit_pc_o,
   output logic                  rf_w_en_o,
   output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
   output logic [XLEN-1:0]       rf_w_data_o,
   output logic [TAG_W:0]        count_o,
   output logic                  empty_o
);

   logic [TAG_W:0]   head, tail;
   logic [TAG_W-1:0] head_idx, tail_idx;
   logic             full, alloc_fire, commit_fire;

   logic [DEPTH-1:0] busy, done;
   rob_info_t        info  [DEPTH];
   logic [XLEN-1:0]  value [DEPTH];

   logic [TAG_W-1:0] wb_tag [NWB];
   logic [NWB-1:0]   wb_hit;

   assign head_idx = head[TAG_W-1:0];
   assign tail_idx = tail[TAG_W-1:0];
   assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

   assign alloc_ready_o = !full;
   assign alloc_tag_o   = tail_idx;
   assign count_o       = tail - head;
   assign empty_o       = (head == tail);

   assign alloc_fire  = alloc_valid_i && !full && !flush_i;
   // Commit looks only at registered done, so a same-cycle writeback to head waits a cycle.
   assign commit_fire = busy[head_idx] && done[head_idx] && !flush_i;

   always_comb begin
      wb_hit = '0;
      for (int unsigned k = 0; k < NWB; k++) begin
         wb_tag[k] = wb_tag_i[k*TAG_W +: TAG_W];
         wb_hit[k] = wb_valid_i[k] && busy[wb_tag[k]];
      end
   end

   rob_ptr #(.TAG_W(TAG_W)) u_head (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (flush_i),
      .inc_i   (commit_fire),
      .ptr_o   (head)
   );

   rob_ptr #(.TAG_W(TAG_W)) u_tail (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (flush_i),
      .inc_i   (alloc_fire),
      .ptr_o   (tail)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy <= '0;
         done <= '0;
      end else if (flush_i) begin
         busy <= '0;
         done <= '0;
      end else begin
         for (int unsigned k = 0; k < NWB; k++) begin
            if (wb_hit[k]) done[wb_tag[k]] <= 1'b1;
         end
         if (commit_fire) busy[head_idx] <= 1'b0;
         if (alloc_fire) begin
            busy[tail_idx] <= 1'b1;
            done[tail_idx] <= 1'b0;
         end
      end
   end

   // Payload needs no reset: it is only read while the matching busy/done bits are set.
   // Ascending port order makes the highest port win on a shared tag.
   always_ff @(posedge clk_i) begin
      if (alloc_fire) begin
         info[tail_idx] <= '{we: alloc_rd_we_i, rd: alloc_rd_addr_i, pc: alloc_pc_i};
      end
      for (int unsigned k = 0; k < NWB; k++) begin
         if (wb_hit[k] && !flush_i) value[wb_tag[k]] <= wb_value_i[k*XLEN +: XLEN];
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         commit_valid_o <= 1'b0;
         commit_tag_o   <= '0;
         commit_pc_o    <= '0;
         rf_w_en_o      <= 1'b0;
         rf_rd_addr_o   <= '0;
         rf_w_data_o    <= '0;
      end else if (commit_fire) begin
         commit_valid_o <= 1'b1;
         commit_tag_o   <= head_idx;
         commit_pc_o    <= info[head_idx].pc;
         rf_w_en_o      <= info[head_idx].we && (info[head_idx].rd != '0);
         rf_rd_addr_o   <= info[head_idx].rd;
         rf_w_data_o    <= value[head_idx];
      end else begin
         commit_valid_o <= 1'b0;
         rf_w_en_o      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a program-order queue model of the buffer.
module tb_reorder_buffer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = 3;
   localparam int unsigned NWB   = 3;

   logic                 clk = 1'b0;
   logic                 reset_i = 1'b0;
   logic                 flush_i = 1'b0;
   logic                 alloc_valid_i = 1'b0;
   logic                 alloc_ready_o;
   logic [TAG_W-1:0]     alloc_tag_o;
   logic [31:0]          alloc_pc_i = '0;
   logic [4:0]           alloc_rd_addr_i = '0;
   logic                 alloc_rd_we_i = 1'b0;
   logic [NWB-1:0]       wb_valid_i = '0;
   logic [NWB*TAG_W-1:0] wb_tag_i = '0;
   logic [NWB*32-1:0]    wb_value_i = '0;
   logic                 commit_valid_o;
   logic [TAG_W-1:0]     commit_tag_o;
   logic [31:0]          commit_pc_o;
   logic                 rf_w_en_o;
   logic [4:0]           rf_rd_addr_o;
   logic [31:0]          rf_w_data_o;
   logic [TAG_W:0]       count_o;
   logic                 empty_o;

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NWB(NWB)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .flush_i         (flush_i),
      .alloc_valid_i   (alloc_valid_i),
      .alloc_ready_o   (alloc_ready_o),
      .alloc_tag_o     (alloc_tag_o),
      .alloc_pc_i      (alloc_pc_i),
      .alloc_rd_addr_i (alloc_rd_addr_i),
      .alloc_rd_we_i   (alloc_rd_we_i),
      .wb_valid_i      (wb_valid_i),
      .wb_tag_i        (wb_tag_i),
      .wb_value_i      (wb_value_i),
      .commit_valid_o  (commit_valid_o),
      .commit_tag_o    (commit_tag_o),
      .commit_pc_o     (commit_pc_o),
      .rf_w_en_o       (rf_w_en_o),
      .rf_rd_addr_o    (rf_rd_addr_o),
      .rf_w_data_o     (rf_w_data_o),
      .count_o         (count_o),
      .empty_o         (empty_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model: in-flight instructions in program order
   typedef struct {
      int unsigned tag;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      bit          done;
      logic [31:0] val;
   } ent_t;

   ent_t        q[$];
   int unsigned next_tag;
   logic        e_cv, e_wen;
   logic [2:0]  e_ctag;
   logic [31:0] e_cpc, e_wdata;
   logic [4:0]  e_rd;

   task automatic model_reset();
      q.delete();
      next_tag = 0;
      e_cv = 0; e_wen = 0; e_ctag = '0; e_cpc = '0; e_wdata = '0; e_rd = '0;
   endtask

   // One clock edge: retire decision and fullness use the state before the edge.
   task automatic model_edge();
      bit was_full;
      ent_t n;
      if (flush_i) begin
         q.delete();
         next_tag = 0;
         e_cv = 0;
         e_wen = 0;
         return;
      end
      was_full = (q.size() == DEPTH);
      if (q.size() > 0 && q[0].done) begin
         e_cv    = 1;
         e_ctag  = 3'(q[0].tag);
         e_cpc   = q[0].pc;
         e_rd    = q[0].rd;
         e_wdata = q[0].val;
         e_wen   = q[0].we && (q[0].rd != 0);
         void'(q.pop_front());
      end else begin
         e_cv  = 0;
         e_wen = 0;
      end
      for (int k = 0; k < NWB; k++) begin
         if (wb_valid_i[k]) begin
            foreach (q[i]) begin
               if (q[i].tag == int'(wb_tag_i[k*TAG_W +: TAG_W])) begin
                  q[i].done = 1;
                  q[i].val  = wb_value_i[k*32 +: 32];
               end
            end
         end
      end
      if (alloc_valid_i && !was_full) begin
         n.tag = next_tag; n.pc = alloc_pc_i; n.rd = alloc_rd_addr_i;
         n.we = alloc_rd_we_i; n.done = 0; n.val = '0;
         q.push_back(n);
         next_tag = (next_tag + 1) % DEPTH;
      end
   endtask

   function automatic logic [82:0] pack_dut();
      return {commit_valid_o, commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o,
              rf_w_data_o, count_o, alloc_ready_o, empty_o, alloc_tag_o};
   endfunction

   function automatic logic [82:0] pack_exp();
      return {e_cv, e_ctag, e_cpc, e_wen, e_rd, e_wdata, 4'(q.size()),
              q.size() < DEPTH, q.size() == 0, 3'(next_tag)};
   endfunction

   // ---------------- stimulus helpers (no checking)
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_idle();
      flush_i = 0; alloc_valid_i = 0; alloc_pc_i = '0; alloc_rd_addr_i = '0;
      alloc_rd_we_i = 0; wb_valid_i = '0; wb_tag_i = '0; wb_value_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_i = 0;
      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      reset_i = 1;
   endtask

   task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we);
      alloc_valid_i = 1; alloc_pc_i = pc; alloc_rd_addr_i = rd; alloc_rd_we_i = we;
   endtask

   task automatic put_wb(input int k, input logic [2:0] t, input logic [31:0] v);
      wb_valid_i[k] = 1;
      wb_tag_i[k*TAG_W +: TAG_W] = t;
      wb_value_i[k*32 +: 32] = v;
   endtask

   // ---------------- tests
   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got tag=%0d pc=%h wen=%b rd=%0d data=%h, expected all zero",
                  commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         n_tests++;
         if ({alloc_ready_o, empty_o, count_o, commit_valid_o} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got ready=%b empty=%b count=%0d cv=%b, expected 1 1 0 0",
                     c, alloc_ready_o, empty_o, count_o, commit_valid_o);
         end
      end
   endtask

   task automatic test_inorder();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_alloc(32'h100 + 32'(4 * i), 5'(5 + i), 1);
         n_tests++;
         if (alloc_tag_o !== 3'(i)) begin
            n_fail++;
            $display("FAIL inorder_alloc_tag: got %0d expected %0d", alloc_tag_o, i);
         end
         tick();
      end
      set_idle();
      put_wb(0, 3'd1, 32'hA);
      tick();
      set_idle();
      tick();
      put_wb(1, 3'd0, 32'hB);
      tick();
      set_idle();
      n_tests++;
      if (commit_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL inorder_wb_edge: got cv=%b expected 0", commit_valid_o);
      end
      tick();
      n_tests++;
      if ({commit_valid_o, commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o} !==
          {1'b1, 3'd0, 32'h100, 1'b1, 5'd5, 32'hB}) begin
         n_fail++;
         $display("FAIL inorder_commit0: got cv=%b tag=%0d pc=%h wen=%b rd=%0d data=%h expected 1 0 100 1 5 b",
                  commit_valid_o, commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o);
      end
      tick();
      n_tests++;
      if ({commit_valid_o, commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o} !==
          {1'b1, 3'd1, 32'h104, 1'b1, 5'd6, 32'hA}) begin
         n_fail++;
         $display("FAIL inorder_commit1: got cv=%b tag=%0d pc=%h wen=%b rd=%0d data=%h expected 1 1 104 1 6 a",
                  commit_valid_o, commit_tag_o, commit_pc_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         n_tests++;
         if ({commit_valid_o, rf_w_en_o, count_o} !== {1'b0, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL inorder_tag2_waits[%0d]: got cv=%b wen=%b count=%0d expected 0 0 1",
                     c, commit_valid_o, rf_w_en_o, count_o);
         end
      end
   endtask

   task automatic test_full();
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_alloc($urandom, 5'($urandom_range(1, 31)), 1);
         tick();
      end
      set_idle();
      n_tests++;
      if ({alloc_ready_o, count_o, empty_o} !== {1'b0, 4'd8, 1'b0}) begin
         n_fail++;
         $display("FAIL full_state: got ready=%b count=%0d empty=%b expected 0 8 0",
                  alloc_ready_o, count_o, empty_o);
      end
      set_alloc(32'hDEAD_BEEF, 5'd1, 1);
      tick();
      set_idle();
      n_tests++;
      if ({alloc_ready_o, count_o, alloc_tag_o} !== {1'b0, 4'd8, 3'd0}) begin
         n_fail++;
         $display("FAIL full_ignore9: got ready=%b count=%0d tag=%0d expected 0 8 0",
                  alloc_ready_o, count_o, alloc_tag_o);
      end
      v = $urandom;
      put_wb(2, 3'd0, v);
      tick();
      set_idle();
      tick();
      n_tests++;
      if ({commit_valid_o, commit_tag_o, rf_w_data_o, alloc_ready_o, count_o} !==
          {1'b1, 3'd0, v, 1'b1, 4'd7}) begin
         n_fail++;
         $display("FAIL full_drain: got cv=%b tag=%0d data=%h ready=%b count=%0d expected 1 0 %h 1 7",
                  commit_valid_o, commit_tag_o, rf_w_data_o, alloc_ready_o, count_o, v);
      end
      n_tests++;
      if (pack_dut() !== pack_exp()) begin
         n_fail++;
         $display("FAIL full_model: got %h expected %h", pack_dut(), pack_exp());
      end
   endtask

   task automatic test_wrap_random();
      int commits = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         set_idle();
         if ($urandom_range(0, 3) != 0) set_alloc($urandom, 5'($urandom), 1'($urandom));
         for (int k = 0; k < NWB; k++) begin
            if (q.size() > 0 && $urandom_range(0, 2) == 0)
               put_wb(k, 3'(q[$urandom_range(0, q.size() - 1)].tag), $urandom);
            else if ($urandom_range(0, 7) == 0)
               put_wb(k, 3'($urandom), $urandom);
         end
         tick();
         if (commit_valid_o === 1'b1) commits++;
         n_tests++;
         if (pack_dut() !== pack_exp()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h expected %h", c, pack_dut(), pack_exp());
         end
         n_tests++;
         if (count_o > 4'd8) begin
            n_fail++;
            $display("FAIL random_count_bound[%0d]: got %0d expected <= 8", c, count_o);
         end
      end
      set_idle();
      n_tests++;
      if (commits < 20) begin
         n_fail++;
         $display("FAIL random_commits: got %0d expected >= 20", commits);
      end
   endtask

   task automatic test_rd0();
      do_reset();
      set_alloc(32'h200, 5'd0, 1); tick();
      set_alloc(32'h204, 5'd9, 0); tick();
      set_alloc(32'h208, 5'd3, 1); tick();
      set_idle();
      put_wb(0, 3'd0, 32'h11);
      put_wb(1, 3'd1, 32'h22);
      put_wb(2, 3'd2, 32'h33);
      tick();
      set_idle();
      tick();
      n_tests++;
      if ({commit_valid_o, rf_w_en_o, commit_tag_o, rf_rd_addr_o} !== {1'b1, 1'b0, 3'd0, 5'd0}) begin
         n_fail++;
         $display("FAIL rd0_commit: got cv=%b wen=%b tag=%0d rd=%0d expected 1 0 0 0",
                  commit_valid_o, rf_w_en_o, commit_tag_o, rf_rd_addr_o);
      end
      tick();
      n_tests++;
      if ({commit_valid_o, rf_w_en_o, commit_tag_o, rf_rd_addr_o} !== {1'b1, 1'b0, 3'd1, 5'd9}) begin
         n_fail++;
         $display("FAIL we0_commit: got cv=%b wen=%b tag=%0d rd=%0d expected 1 0 1 9",
                  commit_valid_o, rf_w_en_o, commit_tag_o, rf_rd_addr_o);
      end
      tick();
      n_tests++;
      if ({commit_valid_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o} !== {1'b1, 1'b1, 5'd3, 32'h33}) begin
         n_fail++;
         $display("FAIL we1_commit: got cv=%b wen=%b rd=%0d data=%h expected 1 1 3 33",
                  commit_valid_o, rf_w_en_o, rf_rd_addr_o, rf_w_data_o);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_alloc(32'h300 + 32'(4 * i), 5'(i + 1), 1);
         if (i == 4) begin
            put_wb(0, 3'd0, 32'h55);
            put_wb(1, 3'd1, 32'h66);
         end
         tick();
      end
      set_idle();
      flush_i = 1;
      set_alloc(32'h400, 5'd2, 1);
      put_wb(2, 3'd2, 32'h77);
      tick();
      set_idle();
      n_tests++;
      if ({count_o, empty_o, commit_valid_o, rf_w_en_o, alloc_tag_o} !== {4'd0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL flush_state: got count=%0d empty=%b cv=%b wen=%b tag=%0d expected 0 1 0 0 0",
                  count_o, empty_o, commit_valid_o, rf_w_en_o, alloc_tag_o);
      end
      tick();
      n_tests++;
      if ({commit_valid_o, count_o} !== {1'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL flush_no_commit: got cv=%b count=%0d expected 0 0", commit_valid_o, count_o);
      end
      set_alloc(32'h500, 5'd4, 1);
      tick();
      set_idle();
      n_tests++;
      if (pack_dut() !== pack_exp()) begin
         n_fail++;
         $display("FAIL flush_realloc: got %h expected %h", pack_dut(), pack_exp());
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_alloc($urandom, 5'($urandom_range(1, 31)), 1);
         if (i > 0) put_wb(0, 3'(i - 1), $urandom);
         tick();
         set_idle();
      end
      tick();
      #2;
      reset_i = 0;
      set_idle();
      model_reset();
      #1;
      n_tests++;
      if ({count_o, empty_o, alloc_ready_o, commit_valid_o, rf_w_en_o, commit_tag_o, rf_w_data_o} !==
          {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL async_reset: got count=%0d empty=%b ready=%b cv=%b wen=%b tag=%0d data=%h expected 0 1 1 0 0 0 0",
                  count_o, empty_o, alloc_ready_o, commit_valid_o, rf_w_en_o, commit_tag_o, rf_w_data_o);
      end
      @(negedge clk);
      reset_i = 1;
      set_alloc(32'h600, 5'd8, 1);
      n_tests++;
      if (alloc_tag_o !== 3'd0) begin
         n_fail++;
         $display("FAIL async_reset_tag: got %0d expected 0", alloc_tag_o);
      end
      tick();
      set_idle();
      n_tests++;
      if (pack_dut() !== pack_exp()) begin
         n_fail++;
         $display("FAIL async_reset_realloc: got %h expected %h", pack_dut(), pack_exp());
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_inorder();
      test_full();
      test_wrap_random();
      test_rd0();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order completion end of the core's issue path. Decode/dispatch allocates an entry per instruction in program order and receives a tag. Arith/mul/lsu return results out of order by tag.
- The buffer retires entries strictly in order and drives the regfile write port (w_en_i / rd_addr_i / w_data_i).
- Sits between decode/rs on one side and regfile on the other, filling the "Reorder Buffer" slot in core.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- TAG_W, 3, log2(DEPTH).
- NWB, 3, writeback ports; index 0 = arith, 1 = mul, 2 = lsu.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush of all entries
- alloc_valid_i  in  1  dispatch requests an entry
- alloc_ready_o  out  1  entry available (not full)
- alloc_tag_o  out  TAG_W  tag assigned to the current request (tail index)
- alloc_pc_i  in  32  instruction PC
- alloc_rd_addr_i  in  5  architectural destination
- alloc_rd_we_i  in  1  instruction writes rd
- wb_valid_i  in  NWB  per-port result valid
- wb_tag_i  in  NWB*TAG_W  per-port tag; port k at bits [k*TAG_W +: TAG_W]
- wb_value_i  in  NWB*32  per-port result; port k at bits [k*32 +: 32]
- commit_valid_o  out  1  one-cycle retire pulse
- commit_tag_o  out  TAG_W  tag retired
- commit_pc_o  out  32  PC retired
- rf_w_en_o  out  1  regfile write enable
- rf_rd_addr_o  out  5  regfile write address
- rf_w_data_o  out  32  regfile write data
- count_o  out  TAG_W+1  occupied entries
- empty_o  out  1  count_o == 0

Behaviour:
- State:
  - head and tail pointers, each TAG_W+1 bits with a wrap bit.
  - Per-entry busy, done, we, rd[4:0], pc[31:0], value[31:0].
- Full/empty:
  - Full = index bits equal and wrap bits differ.
  - Empty = pointers equal.
  - count_o = tail - head, modulo 2^(TAG_W+1).
- Reset (reset_i low, asynchronous):
  - head, tail, all busy/done = 0.
  - commit_valid_o, rf_w_en_o = 0; commit_tag_o, commit_pc_o, rf_rd_addr_o, rf_w_data_o = 0.
  - Hence alloc_ready_o = 1, count_o = 0, empty_o = 1.
  - Asserting reset mid-operation discards all entries.
- Allocation:
  - alloc_ready_o = !full, combinational from registered state only. It does not consider a same-cycle commit.
  - alloc_tag_o = tail index, combinational and valid in the request cycle.
  - On alloc_valid_i && alloc_ready_o at the edge: entry[tail] gets busy=1, done=0 and the captured fields; tail increments.
  - alloc_valid_i while full is ignored and no state changes.
- Writeback:
  - Each port k with wb_valid_i[k] and busy[tag] sets done=1 and value=wb_value_i[k] at the edge.
  - Writeback to a non-busy entry is ignored.
  - Several ports naming the same tag in one cycle: the highest port index wins.
- Commit:
  - Evaluated each cycle from registered state: if busy[head] && done[head], at the edge:
    - commit_valid_o <= 1; commit_tag_o, commit_pc_o, rf_rd_addr_o <= entry fields; rf_w_data_o <= value.
    - rf_w_en_o <= we && (rd != 0).
    - busy[head] <= 0; head increments.
  - Otherwise commit_valid_o and rf_w_en_o go to 0; the data outputs hold their values.
  - At most one retire per cycle.
  - Latency: writeback sampled at edge E → commit outputs visible after edge E+1, i.e. 2 cycles from writeback presentation to the regfile write strobe.
  - An entry allocated at edge E can commit no earlier than one cycle after its writeback is sampled.
- Simultaneous events:
  - Alloc and commit in the same cycle are both performed; count_o nets to unchanged.
  - Writeback to head in the same cycle as the head commit check: the commit waits one cycle.
- Pointer wrap: index wraps DEPTH-1 → 0 and the wrap bit toggles; behaviour is otherwise identical.
- Flush (flush_i high at the edge):
  - head = tail = 0; all busy/done cleared; commit_valid_o, rf_w_en_o <= 0.
  - Flush overrides alloc, writeback and commit in the same cycle.

Decomposition:
- Shared include/package: XLEN=32, REG_ADDR_W=5, ROB_DEPTH, ROB_TAG_W, NWB, and the port-index constants WB_ARITH=0, WB_MUL=1, WB_LSU=2. The rs and FUs reuse the tag width from the same place.
- One sub-module, rob_ptr: a TAG_W+1 wrap-bit pointer with inc and clear. It is instantiated for head and tail, and full/empty are derived from the pair.

Test Plan:
- Reset, then idle → alloc_ready_o=1, empty_o=1, count_o=0, commit_valid_o=0 for 10 cycles.
- Allocate tags 0,1,2 (rd=5,6,7, we=1). Writeback 1 on port 0 at cycle 10 and 0 on port 1 at cycle 12, values 0xA/0xB → tag 0 commits (rd=5, data 0xB) one cycle after its writeback is sampled. Tag 1 follows next cycle (rd=6, 0xA). Tag 2 never commits.
- Allocate 8 without writeback → alloc_ready_o=0, count_o=8. A 9th alloc_valid_i is ignored. Writeback tag 0 → commit, then alloc_ready_o=1.
- Run 20 alloc/writeback/commit rounds → tags wrap 7→0, commits stay in program order, count_o never exceeds 8.
- Entry with rd=0, we=1 completes → commit_valid_o=1, rf_w_en_o=0. Entry with we=0 gives the same response.
- Fill 5 entries and complete 2, then pulse flush_i together with alloc and writeback → count_o=0, no commit pulse, next alloc_tag_o=0. Async reset mid-stream gives the same result immediately.
